// File: rtl/sipo_frame.sv
// Serial<->parallel frame converter: SIPO receive (mode=0) or PISO transmit (mode=1).
// Latency: data_out/out_valid one cycle after the final strobe of a frame; ser_out valid the cycle after par_load.
// Backpressure: none; load is a per-bit strobe, par_load while busy is dropped.
//
// Optional build macro SIPO_FRAME_PARITY_EN appends one even-parity bit to every frame
// (WIDTH+1 strobes); without it par_err is tied low.
// Ports: clk; rst (synchronous, active low); mode 0=SIPO / 1=PISO; load bit strobe;
//        data_in serial in; par_in/par_load parallel word to send; data_out last received
//        word; ser_out serial out; out_valid frame-done pulse; busy transmit in progress;
//        bit_cnt bits shifted in the current frame; par_err received parity mismatch.
module sipo_frame #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         load,
    input  logic                         data_in,
    input  logic [WIDTH-1:0]             par_in,
    input  logic                         par_load,
    output logic [WIDTH-1:0]             data_out,
    output logic                         ser_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                         par_err
);

    localparam int CW = $clog2(WIDTH+1);
`ifdef SIPO_FRAME_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    // bit_cnt value seen on the strobe that closes a frame
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic [1:0] {
        IDLE,
        RX,
        TX
    } state_t;

    state_t           state;
    logic             mode_q;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic             ser_bit;

    // Receive and transmit shift the same direction: the first bit on the wire
    // is the word end selected by MSB_FIRST.
    always_comb begin
        if (MSB_FIRST) begin
            rx_shift = {shreg[WIDTH-2:0], data_in};
            tx_shift = {shreg[WIDTH-2:0], 1'b0};
            ser_bit  = shreg[WIDTH-1];
        end else begin
            rx_shift = {data_in, shreg[WIDTH-1:1]};
            tx_shift = {1'b0, shreg[WIDTH-1:1]};
            ser_bit  = shreg[0];
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    localparam logic [CW-1:0] PAR_SLOT = CW'(WIDTH);
    logic par_bit;  // even parity of the word being transmitted

    // Once all data bits are out, the parity slot replaces the (now empty) shift register.
    assign ser_out = (state == TX && bit_cnt == PAR_SLOT) ? par_bit : ser_bit;
`else
    assign ser_out = ser_bit;
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= mode;  // no spurious abort on the first cycle after reset
            shreg     <= '0;
            data_out  <= '0;
            bit_cnt   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
            par_err   <= 1'b0;
            par_bit   <= 1'b0;
`endif
        end else begin
            mode_q    <= mode;
            out_valid <= 1'b0;
            if (mode != mode_q) begin
                // Direction switch abandons the frame; data_out keeps the last good word.
                state   <= IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
                shreg   <= '0;
            end else if (!mode) begin
                if (load) begin
                    if (bit_cnt == LAST) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        out_valid <= 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
                        // Final strobe carries parity; the word is already assembled.
                        data_out  <= shreg;
                        par_err   <= (^shreg) ^ data_in;
`else
                        shreg     <= rx_shift;
                        data_out  <= rx_shift;
`endif
                    end else begin
                        state   <= RX;
                        bit_cnt <= bit_cnt + CW'(1);
                        shreg   <= rx_shift;
                    end
                end
            end else begin
                case (state)
                    TX: begin
                        if (load) begin
                            shreg <= tx_shift;
                            if (bit_cnt == LAST) begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                bit_cnt   <= '0;
                                out_valid <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        // A strobe in the par_load cycle is ignored; the first bit
                        // goes out on the next strobe.
                        if (par_load) begin
                            shreg   <= par_in;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                            state   <= TX;
`ifdef SIPO_FRAME_PARITY_EN
                            par_bit <= ^par_in;
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule
